// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache.
// Hits are combinational; a miss latches the request and fills one word from memory.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_reg, state_next;
    logic [SETS-1:0]   valid_reg;
    logic [TAG_W-1:0]  tag_mem [SETS];
    logic [31:0]       data_mem [SETS];
    logic [29:0]       fetch_addr_reg;
    logic [31:0]       hit_count_reg;
    logic [31:0]       miss_count_reg;

    logic [IDX_W-1:0]  req_index;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_index;
    logic [TAG_W-1:0]  fill_tag;
    logic              lookup_hit;
    logic              miss;
    logic              fill;
    logic [SETS-1:0]   fill_sel;
    logic [1:0]        unused_byte_offset;

    assign unused_byte_offset = imemaddr[1:0];
    assign req_index  = imemaddr[IDX_W+1:2];
    assign req_tag    = imemaddr[31:IDX_W+2];
    assign fill_index = fetch_addr_reg[IDX_W-1:0];
    assign fill_tag   = fetch_addr_reg[29:IDX_W];
    assign lookup_hit = valid_reg[req_index] && (tag_mem[req_index] == req_tag);

    always_comb begin
        state_next = state_reg;
        ihit       = 1'b0;
        iREN       = 1'b0;
        iaddr      = 32'd0;
        miss       = 1'b0;
        fill       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_hit) begin
                        ihit = 1'b1;
                    end else begin
                        miss       = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                // The fill always targets the latched address, whatever the PC does meanwhile.
                iREN  = 1'b1;
                iaddr = {fetch_addr_reg, 2'b00};
                if (!iwait) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign imemload   = ihit ? data_mem[req_index] : 32'd0;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    for (genvar gi = 0; gi < SETS; gi++) begin : g_fill_sel
        assign fill_sel[gi] = fill && (fill_index == IDX_W'(gi));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            fetch_addr_reg <= 30'd0;
            hit_count_reg  <= 32'd0;
            miss_count_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_reg | fill_sel;
            if (miss) begin
                fetch_addr_reg <= {req_tag, req_index};
            end
            if (ihit && (hit_count_reg != 32'hFFFF_FFFF)) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss && (miss_count_reg != 32'hFFFF_FFFF)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    // Tag and data storage are unreset; valid_reg alone decides what is visible.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, conflicts, mid-fetch address change,
// reset during fill, idle/byte offset and hit counter saturation.
module tb_icache;
    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 2;
    int wait_cnt = 0;

    icache #(.SETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: iwait held for mem_lat cycles of each request.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return {a[15:0], 16'hC0DE};
    endfunction

    assign iload = mem_word(iaddr);
    assign iwait = iREN && (wait_cnt < mem_lat);

    always @(posedge CLK) begin
        if (iREN && iwait) wait_cnt <= wait_cnt + 1;
        else               wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Request addr until ihit, counting the cycles spent with iREN high.
    task automatic access(input string tag, input logic [31:0] addr,
                          input int exp_ren, input logic [31:0] exp_data);
        int  ren_cycles = 0;
        int  n          = 0;
        bit  addr_ok    = 1'b1;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = addr;
        #1;
        while (!ihit && n < 50) begin
            if (iREN) begin
                ren_cycles++;
                if (iaddr !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
            end
            @(negedge CLK);
            #1;
            n++;
        end
        check({tag, " ihit"}, 32'(ihit), 32'd1);
        check({tag, " ren_cycles"}, ren_cycles, exp_ren);
        check({tag, " iaddr"}, 32'(addr_ok), 32'd1);
        check({tag, " imemload"}, imemload, exp_data);
        $display("access %s addr=%h ren_cycles=%0d data=%h", tag, addr, ren_cycles, imemload);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            imemREN = 1'b0;
        end
        #1;
    endtask

    initial begin
        bit ren_seen;
        int n;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst ihit", 32'(ihit), 32'd0);
        check("rst iREN", 32'(iREN), 32'd0);
        check("rst iaddr", iaddr, 32'd0);
        check("rst hits", hit_count, 32'd0);
        check("rst misses", miss_count, 32'd0);
        nRST = 1'b1;

        // Cold miss then hit, latency 2 -> 3 iREN cycles.
        access("cold40", 32'h40, 3, 32'hDEAD_BEEF);
        idle_cycles(1);
        check("cold misses", miss_count, 32'd1);
        check("cold hits", hit_count, 32'd1);

        // Conflict eviction on index 0.
        access("conf80", 32'h80, 3, 32'h0080_C0DE);
        access("conf40", 32'h40, 3, 32'hDEAD_BEEF);
        idle_cycles(1);
        check("conf misses", miss_count, 32'd3);
        check("conf hits", hit_count, 32'd3);

        // Byte offset ignored, then idle leaves everything alone.
        access("off43", 32'h43, 0, 32'hDEAD_BEEF);
        ren_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            imemREN = 1'b0;
            #1;
            if (iREN || ihit) ren_seen = 1'b1;
        end
        check("idle quiet", 32'(ren_seen), 32'd0);
        check("idle misses", miss_count, 32'd3);
        check("idle hits", hit_count, 32'd4);

        // Address change while the fill is stalled.
        mem_lat = 4;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h100;
        #1;
        check("mid miss ihit", 32'(ihit), 32'd0);
        @(negedge CLK);
        imemaddr = 32'h104;
        #1;
        check("mid iREN", 32'(iREN), 32'd1);
        ren_seen = 1'b1;
        n = 0;
        while (iREN && n < 20) begin
            if (iaddr !== 32'h100) ren_seen = 1'b0;
            @(negedge CLK);
            #1;
            n++;
        end
        check("mid iaddr held", 32'(ren_seen), 32'd1);
        check("mid fetch cycles", n, 32'd5);
        access("mid104", 32'h104, 5, 32'h0104_C0DE);
        access("mid100", 32'h100, 0, 32'h0100_C0DE);
        idle_cycles(1);
        check("mid misses", miss_count, 32'd5);

        // imemREN dropped during a fill: fill still completes.
        mem_lat = 2;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h300;
        @(negedge CLK);
        imemREN = 1'b0;
        n = 0;
        #1;
        while (iREN && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("drop fill done", 32'(iREN), 32'd0);
        access("drop300", 32'h300, 0, 32'h0300_C0DE);

        // Reset during a stalled fill.
        mem_lat = 4;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h200;
        @(negedge CLK);
        #1;
        check("rfill iREN", 32'(iREN), 32'd1);
        check("rfill iaddr", iaddr, 32'h200);
        #1;
        nRST = 1'b0;
        #1;
        check("rfill iREN async", 32'(iREN), 32'd0);
        check("rfill iaddr async", iaddr, 32'd0);
        check("rfill hits async", hit_count, 32'd0);
        check("rfill misses async", miss_count, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check("rfill post ihit", 32'(ihit), 32'd0);
        check("rfill post misses", miss_count, 32'd0);
        access("rfill200", 32'h200, 5, 32'h0200_C0DE);
        idle_cycles(1);
        check("rfill misses", miss_count, 32'd1);

        // Hit counter saturation.
        force dut.hit_count_reg = 32'hFFFF_FFFE;
        @(posedge CLK);
        @(negedge CLK);
        release dut.hit_count_reg;
        #1;
        check("sat preset", hit_count, 32'hFFFF_FFFE);
        imemREN  = 1'b1;
        imemaddr = 32'h200;
        repeat (3) @(negedge CLK);
        imemREN = 1'b0;
        #1;
        check("sat hits", hit_count, 32'hFFFF_FFFF);
        $display("saturation hit_count=%h", hit_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The module SHALL have parameter SETS, default 16, giving the number of direct-mapped frames (power of 2, at least 2).
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port nRST, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port imemREN, input, 1 bit: the datapath requests an instruction.
REQ-005 The module SHALL have port imemaddr, input, 32 bits: instruction byte address from the datapath PC.
REQ-006 The module SHALL have port ihit, output, 1 bit: imemload is valid this cycle.
REQ-007 The module SHALL have port imemload, output, 32 bits: the instruction word.
REQ-008 The module SHALL have port iREN, output, 1 bit: read request to the memory controller.
REQ-009 The module SHALL have port iaddr, output, 32 bits: word-aligned memory read address.
REQ-010 The module SHALL have port iwait, input, 1 bit: memory busy; iload is valid when iREN=1 and iwait=0.
REQ-011 The module SHALL have port iload, input, 32 bits: memory read data.
REQ-012 The module SHALL have port hit_count, output, 32 bits: number of ihit cycles.
REQ-013 The module SHALL have port miss_count, output, 32 bits: number of misses.

Function
REQ-014 Address split SHALL be: byte offset = imemaddr[1:0], ignored; index = next log2(SETS) bits; tag = remaining upper bits.
REQ-015 Each frame SHALL hold a valid bit, a tag and one 32-bit word.
REQ-016 The FSM SHALL have two states, IDLE and FETCH.
REQ-017 In IDLE: ihit = imemREN AND valid[index] AND tag match; this SHALL be combinational, with 0 cycles of latency.
REQ-018 imemload SHALL equal data[index] whenever ihit=1; otherwise it SHALL be 0.
REQ-019 In IDLE with imemREN=1 and a miss: latch {tag, index}, increment miss_count, and go to FETCH at the next edge.
REQ-020 In IDLE: iREN SHALL be 0.
REQ-021 In FETCH: iREN=1 and iaddr = {latched tag, latched index, 2'b00}; ihit SHALL be 0.
REQ-022 In FETCH with iwait=1: remain in FETCH, with iaddr held stable.
REQ-023 In FETCH with iwait=0: write iload, latched tag and valid=1 into the latched frame, and return to IDLE.
REQ-024 The filled frame SHALL hit one cycle later if imemaddr is unchanged, giving a miss penalty of memory latency + 1 cycle.
REQ-025 A fill SHALL always use the latched address; changes to imemaddr or imemREN during FETCH SHALL NOT abort or redirect the fill.
REQ-026 If imemREN drops during FETCH, the fill SHALL still complete and return to IDLE.
REQ-027 A fill SHALL overwrite the frame unconditionally; instruction frames are never dirty and there is no writeback.
REQ-028 In IDLE with imemREN=0: no hit, no miss, no state change.
REQ-029 hit_count SHALL increment by 1 on every cycle with ihit=1.
REQ-030 Both counters SHALL saturate at 32'hFFFFFFFF and SHALL NOT wrap.
REQ-031 iaddr SHALL be 0 when iREN=0.

Reset
REQ-032 When nRST=0, the module SHALL immediately and asynchronously enter IDLE and clear all valid bits.
REQ-033 While nRST=0, hit_count and miss_count SHALL be 0, the latched address 0, and ihit, iREN and iaddr 0.
REQ-034 Reset asserted during FETCH SHALL abort the fill; no frame is written, and iREN drops without waiting for the clock.
REQ-035 Data and tag storage need not be reset; they are never observable while valid=0.

Verification
REQ-036 The bench SHALL cover a cold miss then hit: after reset, imemREN=1, imemaddr=0x00000040, memory latency 2 cycles, iload=0xDEADBEEF -> iREN=1 with iaddr=0x40 for 3 cycles; fill; next cycle ihit=1, imemload=0xDEADBEEF, miss_count=1, hit_count=1.
REQ-037 The bench SHALL cover a conflict eviction (SETS=16): fill 0x00000040, then access 0x00000080 -> miss on the same index 0, frame replaced; re-accessing 0x40 misses again; miss_count=3.
REQ-038 The bench SHALL cover an address change mid-fetch: miss on 0x100, then switch imemaddr to 0x104 while iwait=1 -> iaddr stays 0x100 until iwait=0; frame for 0x100 is valid; 0x104 then misses separately.
REQ-039 The bench SHALL cover reset mid-fill: assert nRST=0 while in FETCH for 0x200 -> iREN=0 immediately; after release, an access to 0x200 misses (valid cleared) and the counters read 0 before it.
REQ-040 The bench SHALL cover idle and byte offset: imemREN=0 for 10 cycles -> iREN=0 and counters unchanged; a filled 0x40 followed by imemaddr=0x43 -> hit (offset ignored).
REQ-041 The bench SHALL cover counter saturation: force hit_count to 32'hFFFFFFFE, apply 3 hit cycles -> hit_count=32'hFFFFFFFF.
